// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue
//   Fetch front end feeding instruction_decoder. Issues sequential word fetches
//   to instruction memory with one request outstanding at a time. Returned words
//   and their PCs are buffered in a DEPTH-entry FIFO, and the FIFO head is
//   presented to the decoder. Control-flow redirects flush the queue. A request
//   that is still in flight when a redirect arrives is drained and its data is
//   discarded. A misaligned redirect target halts fetch and raises a fault.
//
// Ports
//   clk, n_rst            clock; asynchronous active-low reset
//   redirect, redirect_pc single-cycle redirect pulse and its target PC
//   mem_req, mem_addr     fetch request and word address (driven from registers)
//   mem_ack, mem_rdata    request accepted; returned word valid in the same cycle
//   instruction, inst_pc  FIFO head word and its PC (registered)
//   n_irdy                active-low: head entry valid
//   n_stall               active-low stall; 1 = decoder takes the head this edge
//   n_fetch_fault         active-low: misaligned redirect target, fetch halted
//   fetch_state           debug view of the fetch FSM (0 IDLE, 1 FETCH, 2 DRAIN, 3 FAULT)
//
// Handshakes
//   Memory: a request transfers on any edge with mem_req=1 and mem_ack=1.
//   mem_addr is held stable while mem_req=1 and mem_ack=0.
//   Decoder: the head transfers on any edge with n_irdy=0 and n_stall=1.
//   instruction and inst_pc are held stable while n_irdy=0 and n_stall=0.
module instruction_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        n_irdy,
  input  logic        n_stall,
  output logic        n_fetch_fault,
  output logic [1:0]  fetch_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   pending_pc, pending_pc_next;   // redirect target parked during DRAIN
  logic          fault_pending, fault_pending_next;
  logic [CW-1:0] count, count_next;
  logic [PW-1:0] rd_ptr, rd_ptr_next, wr_ptr, wr_ptr_next;
  logic [31:0]   head_inst, head_inst_next, head_pc, head_pc_next;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic          push, pop, misaligned;

  assign misaligned = (redirect_pc[1:0] != 2'b00);
  // A redirect overrides both queue operations in the same cycle.
  assign push = (state == FETCH) && mem_ack && !redirect;
  assign pop  = (count != '0) && n_stall && !redirect;

  // Queue bookkeeping and the next head value.
  always_comb begin
    count_next     = count;
    rd_ptr_next    = rd_ptr;
    wr_ptr_next    = wr_ptr;
    head_inst_next = head_inst;
    head_pc_next   = head_pc;
    if (redirect) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      count_next  = count + CW'(push) - CW'(pop);
      rd_ptr_next = rd_ptr + PW'(pop);
      wr_ptr_next = wr_ptr + PW'(push);
      // The head register is loaded with the entry that will sit at the read
      // pointer after this edge. That entry can be the word being written now.
      // When the queue goes empty, the head keeps its last value.
      if (count_next != '0) begin
        if (push && (rd_ptr_next == wr_ptr)) begin
          head_inst_next = mem_rdata;
          head_pc_next   = fetch_pc;
        end else begin
          head_inst_next = inst_mem[rd_ptr_next];
          head_pc_next   = pc_mem[rd_ptr_next];
        end
      end
    end
  end

  // Fetch FSM: next state and next fetch PC.
  always_comb begin
    state_next         = state;
    fetch_pc_next      = fetch_pc;
    pending_pc_next    = pending_pc;
    fault_pending_next = fault_pending;
    case (state)
      IDLE: begin
        if (redirect) begin
          state_next = misaligned ? FAULT : FETCH;
          if (!misaligned) fetch_pc_next = redirect_pc;
        end else if (count < CW'(DEPTH)) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          if (mem_ack) begin
            // The acked word is stale and is dropped.
            state_next = misaligned ? FAULT : FETCH;
            if (!misaligned) fetch_pc_next = redirect_pc;
          end else begin
            // The request is still open. Keep the old address on the bus until
            // memory takes it.
            state_next         = DRAIN;
            pending_pc_next    = redirect_pc;
            fault_pending_next = misaligned;
          end
        end else if (mem_ack) begin
          fetch_pc_next = fetch_pc + 32'd4;
          state_next    = (count_next < CW'(DEPTH)) ? FETCH : IDLE;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          fault_pending_next = 1'b0;
          if (redirect) begin
            state_next = misaligned ? FAULT : FETCH;
            if (!misaligned) fetch_pc_next = redirect_pc;
          end else begin
            state_next = fault_pending ? FAULT : FETCH;
            if (!fault_pending) fetch_pc_next = pending_pc;
          end
        end else if (redirect) begin
          // A later redirect replaces the parked target.
          pending_pc_next    = redirect_pc;
          fault_pending_next = misaligned;
        end
      end
      FAULT: begin
        if (redirect && !misaligned) begin
          state_next    = FETCH;
          fetch_pc_next = redirect_pc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      pending_pc    <= RESET_PC;
      fault_pending <= 1'b0;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      head_inst     <= '0;
      head_pc       <= '0;
    end else begin
      state         <= state_next;
      fetch_pc      <= fetch_pc_next;
      pending_pc    <= pending_pc_next;
      fault_pending <= fault_pending_next;
      count         <= count_next;
      rd_ptr        <= rd_ptr_next;
      wr_ptr        <= wr_ptr_next;
      head_inst     <= head_inst_next;
      head_pc       <= head_pc_next;
    end
  end

  // Storage has no reset. An entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= mem_rdata;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

  assign mem_req       = (state == FETCH) || (state == DRAIN);
  assign mem_addr      = fetch_pc;
  assign n_irdy        = (count == '0);
  assign n_fetch_fault = (state != FAULT);
  assign instruction   = head_inst;
  assign inst_pc       = head_pc;
  assign fetch_state   = state;

endmodule
